mem_port_arbiter: RTL

Shares one single-ported unified memory bus between the instruction-fetch port and the MEM-stage load/store port of the 5-stage RV32I pipeline. It sequences each access through a small FSM and returns a one-cycle acknowledge with read data. It drives per-port stall signals into the pipeline's existing stall path. It sits between the INSTRUCTION_FETCH/MEM_STAGE blocks and the external memory.

---
 rtl/memarb_pkg.sv | 9 +
 rtl/memarb_if.sv | 38 +++
 rtl/memarb_wdog.sv | 21 ++
 rtl/mem_port_arbiter.sv | 89 ++++++++
 4 files changed

// File: rtl/memarb_pkg.sv
// memarb_pkg: shared types and default widths for the memory port arbiter.
package memarb_pkg;
    localparam int ADDR_W_DEF   = 32;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_WAIT_DEF = 15;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;
endpackage

// File: rtl/memarb_if.sv
// memarb_if: fetch port, load/store port and external bus of the memory port arbiter.
interface memarb_if #(
    parameter int ADDR_W = memarb_pkg::ADDR_W_DEF,
    parameter int DATA_W = memarb_pkg::DATA_W_DEF
);
    logic                if_req;
    logic [ADDR_W-1:0]   if_addr;
    logic [DATA_W-1:0]   if_rdata;
    logic                if_ack;
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_be;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_ack;
    logic                bus_req;
    logic                bus_we;
    logic [ADDR_W-1:0]   bus_addr;
    logic [DATA_W-1:0]   bus_wdata;
    logic [DATA_W/8-1:0] bus_be;
    logic [DATA_W-1:0]   bus_rdata;
    logic                bus_ready;
    logic                if_stall;
    logic                mem_stall;
    logic                bus_err;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_be, bus_rdata, bus_ready,
        output if_rdata, if_ack, mem_rdata, mem_ack, bus_req, bus_we, bus_addr, bus_wdata, bus_be,
               if_stall, mem_stall, bus_err
    );
    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_be, bus_rdata, bus_ready,
        input  if_rdata, if_ack, mem_rdata, mem_ack, bus_req, bus_we, bus_addr, bus_wdata, bus_be,
               if_stall, mem_stall, bus_err
    );
endinterface

// File: rtl/memarb_wdog.sv
// memarb_wdog: saturating bus wait counter; timeout once MAX_WAIT unready cycles have elapsed.
module memarb_wdog #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    localparam int W = $clog2(MAX_WAIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && !timeout) cnt <= cnt + 1'b1;

    assign timeout = cnt == W'(MAX_WAIT);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between fetch and load/store ports (IDLE->BUSY->DONE).
// Define MEMARB_RR_EN for round-robin tie-breaking; otherwise the mem port always wins ties.
module mem_port_arbiter
    import memarb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input logic       clk,
    input logic       reset,
    memarb_if.slave   port
);
    state_t state, state_nx;
    owner_t owner;
    logic   err, win_mem, timeout, any_req;

    assign any_req = port.if_req | port.mem_req;

`ifdef MEMARB_RR_EN
    logic last_if;
    // last_if set means the previous tie went to fetch, so mem takes the next one
    assign win_mem = (port.if_req & port.mem_req) ? last_if : port.mem_req;
    always_ff @(posedge clk or negedge reset)
        if (!reset) last_if <= 1'b1;
        else if (state == IDLE && port.if_req && port.mem_req) last_if <= ~win_mem;
`else
    assign win_mem = port.mem_req;
`endif

    memarb_wdog #(.MAX_WAIT(MAX_WAIT)) u_wdog (
        .clk(clk),
        .reset(reset),
        .clr(state == IDLE),
        .en(state == BUSY && !port.bus_ready),
        .timeout(timeout)
    );

    always_comb begin
        state_nx     = IDLE;
        port.bus_req = 1'b0;
        port.if_ack  = 1'b0;
        port.mem_ack = 1'b0;
        port.bus_err = 1'b0;
        case (state)
            IDLE: state_nx = any_req ? BUSY : IDLE;
            BUSY: begin
                port.bus_req = 1'b1;
                state_nx     = (port.bus_ready | timeout) ? DONE : BUSY;
            end
            default: begin
                port.if_ack  = owner == OWN_IF;
                port.mem_ack = owner == OWN_MEM;
                port.bus_err = err;
            end
        endcase
        port.if_stall  = port.if_req & ~port.if_ack;
        port.mem_stall = port.mem_req & ~port.mem_ack;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state          <= IDLE;
            owner          <= OWN_IF;
            err            <= 1'b0;
            port.if_rdata  <= '0;
            port.mem_rdata <= '0;
            port.bus_we    <= 1'b0;
            port.bus_addr  <= '0;
            port.bus_wdata <= '0;
            port.bus_be    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                err <= 1'b0;
                if (any_req) begin
                    owner          <= win_mem ? OWN_MEM : OWN_IF;
                    port.bus_we    <= win_mem & port.mem_we;
                    port.bus_addr  <= win_mem ? port.mem_addr : port.if_addr;
                    port.bus_wdata <= win_mem ? port.mem_wdata : '0;
                    port.bus_be    <= win_mem ? port.mem_be : '1;
                end
            end
            // a timed-out transfer returns zero data; stores always return zero
            if (state == BUSY && (port.bus_ready || timeout)) begin
                err <= ~port.bus_ready;
                if (owner == OWN_IF) port.if_rdata <= port.bus_ready ? port.bus_rdata : '0;
                else port.mem_rdata <= (port.bus_ready & ~port.bus_we) ? port.bus_rdata : '0;
            end
        end
endmodule
